instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction fetch path.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds a per-entry fault bit.
package fetch_pkg;
  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;
  // Widest supported PC; narrower PC_W configurations use the low bits.
  localparam int ENTRY_PC_W = 64;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [ENTRY_PC_W-1:0] pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  fault;
`endif
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetch entries with single-cycle flush and a
// zero-latency head read. DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop; pop on an empty queue is ignored.
  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && (count != '0) && !flush;
  end

  // Entry storage has no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointer wrap is free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues one memory read per cycle while a
// queue slot is reserved, queues the responses, and handles redirects.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-target fault tag).
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_W-1:0]        PC_Out,
  output logic [PC_W-1:0]        PC_In,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_target,
  output logic                   imem_rd_en,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                   out_fault,
`endif
  output logic [$clog2(DEPTH):0] count
);
  logic            issue;
  logic            inflight;
  logic [PC_W-1:0] inflight_pc;
  logic [PC_W-1:0] redirect_pc;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Issue only when the queue has room for every response already owed.
  always_comb begin
    issue = !reset && !redirect && ((int'(count) + int'(inflight)) < DEPTH);
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_pc = redirect_target;
`else
    redirect_pc = {redirect_target[PC_W-1:2], 2'b00};
`endif
    if (reset)         PC_In = PC_Out;
    else if (redirect) PC_In = redirect_pc;
    else if (issue)    PC_In = PC_Out + PC_W'(PC_STEP);
    else               PC_In = PC_Out;
  end

  assign imem_rd_en = issue;
  assign imem_addr  = PC_Out;

  // Track the single outstanding read and the PC it was issued for.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= PC_Out;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_pending;
  logic inflight_fault;

  // Remember a misaligned redirect until its first fetch is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_pending  <= 1'b0;
      inflight_fault <= 1'b0;
    end else begin
      if (redirect)   fault_pending <= |redirect_target[1:0];
      else if (issue) fault_pending <= 1'b0;
      if (issue)      inflight_fault <= fault_pending;
    end
  end
`endif

  // A response arriving alongside a redirect belongs to the old path: drop it.
  always_comb begin
    push             = inflight && !redirect;
    push_entry       = '0;
    push_entry.instr = imem_rdata;
    push_entry.pc    = ENTRY_PC_W'(inflight_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    push_entry.fault = inflight_fault;
`endif
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc[PC_W-1:0];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign out_fault = head.fault;
`endif
endmodule
